mem_wb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/mem_wb_skid_stage_if.sv | 37 +++
 rtl/mem_wb_skid_stage.sv | 116 +++++++++++
 tb/tb_mem_wb_skid_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB handshake bundle: upstream entry fields plus the writeback-side view.
// The environment drives through master; the stage consumes it through slave.
interface mem_wb_skid_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_ir;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_mdr;
    logic [RA_W-1:0] in_rd;
    logic [1:0]      in_wbsel;
    logic            in_regwrite;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_ir;
    logic [RA_W-1:0] out_rd;
    logic [XLEN-1:0] out_wdata;
    logic            out_we;

    modport master (
        output in_valid, in_pc, in_ir, in_alu, in_mdr,
        output in_rd, in_wbsel, in_regwrite, out_ready,
        input  in_ready, out_valid, out_pc, out_ir,
        input  out_rd, out_wdata, out_we
    );

    modport slave (
        input  in_valid, in_pc, in_ir, in_alu, in_mdr,
        input  in_rd, in_wbsel, in_regwrite, out_ready,
        output in_ready, out_valid, out_pc, out_ir,
        output out_rd, out_wdata, out_we
    );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage: output register plus one skid entry, writeback word chosen at capture,
// with retire and stall counters.
module mem_wb_skid_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    mem_wb_skid_stage_if.slave bus,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] wdata;
        logic [RA_W-1:0] rd;
        logic            regwrite;
    } ent_t;

    ent_t            r_out;
    ent_t            r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;
    logic            r_in_ready;
    logic [CNT_W-1:0] r_retire;
    logic [CNT_W-1:0] r_stall;

    ent_t            w_new;
    logic            w_acc;
    logic            w_free;
    logic            w_retire;
    logic            w_stall;

    assign w_acc    = bus.in_valid & r_in_ready;
    assign w_free   = ~r_out_valid | bus.out_ready;
    assign w_retire = r_out_valid & bus.out_ready;
    assign w_stall  = r_out_valid & ~bus.out_ready;

    always_comb begin
        w_new          = '0;
        w_new.pc       = bus.in_pc;
        w_new.ir       = bus.in_ir;
        w_new.rd       = bus.in_rd;
        w_new.regwrite = bus.in_regwrite;
        unique case (bus.in_wbsel)
            2'd0: w_new.wdata = bus.in_alu;
            2'd1: w_new.wdata = bus.in_mdr;
            2'd2: w_new.wdata = bus.in_pc + XLEN'(4);
            2'd3: w_new.wdata = {bus.in_ir[XLEN-1:12], 12'b0};
            default: w_new.wdata = bus.in_alu;
        endcase
    end

    // in_ready tracks "skid empty after this edge"; the skid only fills when the slot is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_free) begin
            if (r_skid_valid) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
                if (w_acc) begin
                    r_skid <= w_new;
                end
                r_skid_valid <= w_acc;
                r_in_ready   <= ~w_acc;
            end else begin
                if (w_acc) begin
                    r_out <= w_new;
                end
                r_out_valid <= w_acc;
                r_in_ready  <= 1'b1;
            end
        end else if (w_acc) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    // stall counting ignores flush; a flushed cycle never counts as a retire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire <= '0;
            r_stall  <= '0;
        end else begin
            if (w_retire && !flush) begin
                r_retire <= r_retire + CNT_W'(1);
            end
            if (w_stall) begin
                r_stall <= r_stall + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_out.pc;
    assign bus.out_ir    = r_out.ir;
    assign bus.out_rd    = r_out.rd;
    assign bus.out_wdata = r_out.wdata;
    assign bus.out_we    = r_out_valid & r_out.regwrite & (r_out.rd != '0);
    assign retire_cnt    = r_retire;
    assign stall_cnt     = r_stall;
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: a 2-deep FIFO model checked every cycle,
// plus literal expectations at the directed test points.
module tb_mem_wb_skid_stage;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;

    mem_wb_skid_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    mem_wb_skid_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        rw;
    } mdl_t;

    mdl_t        q[$];
    logic [31:0] m_ret;
    logic [31:0] m_stall;
    int          n_chk;
    int          n_fail;

    initial begin
        n_chk  = 0;
        n_fail = 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_wb(input logic [1:0] s, input logic [31:0] pc,
                                           input logic [31:0] ir, input logic [31:0] alu,
                                           input logic [31:0] mdr);
        case (s)
            2'd0: return alu;
            2'd1: return mdr;
            2'd2: return pc + 32'd4;
            default: return ir & 32'hFFFF_F000;
        endcase
    endfunction

    // Stage behaves as an ordered queue of at most two entries
    always @(posedge clk) begin
        mdl_t e;
        logic can_take;
        if (rst) begin
            q.delete();
            m_ret   = 0;
            m_stall = 0;
        end else begin
            can_take = (q.size() < 2);
            if (q.size() > 0 && !bus.out_ready) m_stall = m_stall + 1;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && bus.out_ready) begin
                    m_ret = m_ret + 1;
                    void'(q.pop_front());
                end
                if (bus.in_valid && can_take) begin
                    e.pc    = bus.in_pc;
                    e.ir    = bus.in_ir;
                    e.rd    = bus.in_rd;
                    e.rw    = bus.in_regwrite;
                    e.wdata = sel_wb(bus.in_wbsel, bus.in_pc, bus.in_ir, bus.in_alu, bus.in_mdr);
                    q.push_back(e);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("retire_cnt", retire_cnt, m_ret);
        chk("stall_cnt", stall_cnt, m_stall);
        if (q.size() > 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_ir", bus.out_ir, q[0].ir);
            chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
            chk("out_wdata", bus.out_wdata, q[0].wdata);
            chk("out_we", 32'(bus.out_we), 32'(q[0].rw && q[0].rd != 0));
        end else begin
            chk("out_we_idle", 32'(bus.out_we), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                        input logic [31:0] mdr, input logic [4:0] rd, input logic [1:0] ws,
                        input logic rw);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_ir       = ir;
        bus.in_alu      = alu;
        bus.in_mdr      = mdr;
        bus.in_rd       = rd;
        bus.in_wbsel    = ws;
        bus.in_regwrite = rw;
    endtask

    initial begin
        logic [15:0] pat_v;
        logic [15:0] pat_r;
        rst   = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        send(0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_we", 32'(bus.out_we), 32'd0);
        chk("rst retire", retire_cnt, 32'd0);
        chk("rst stall", stall_cnt, 32'd0);
        chk("rst wdata", bus.out_wdata, 32'd0);
        chk("rst pc", bus.out_pc, 32'd0);
        rst = 1'b0;

        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h100 + 32'(4 * i), 32'h13, 32'h10 + 32'(i), 32'hDEAD, 5'd1, 2'd0, 1'b1);
            tick();
            chk("stream wdata", bus.out_wdata, 32'h10 + 32'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("stream retire", retire_cnt, 32'd4);
        chk("stream stall", stall_cnt, 32'd0);

        bus.out_ready = 1'b0;
        send(32'h200, 32'h33, 32'hA, 0, 5'd2, 2'd0, 1'b1);
        tick();
        send(32'h204, 32'h33, 32'hB, 0, 5'd3, 2'd0, 1'b1);
        tick();
        chk("skid in_ready", 32'(bus.in_ready), 32'd0);
        chk("skid hold A", bus.out_pc, 32'h200);
        send(32'h208, 32'h33, 32'hC, 0, 5'd4, 2'd0, 1'b1);
        tick();
        chk("skid C blocked", bus.out_pc, 32'h200);
        bus.out_ready = 1'b1;
        tick();
        chk("order B", bus.out_wdata, 32'hB);
        tick();
        chk("order C", bus.out_wdata, 32'hC);
        bus.in_valid = 1'b0;
        tick();

        send(32'hFFFF_FFFC, 32'h6F, 32'h5, 32'h6, 5'd7, 2'd2, 1'b1);
        tick();
        chk("pc+4 wrap", bus.out_wdata, 32'd0);
        send(32'h300, 32'h1234_5037, 32'h5, 32'h6, 5'd8, 2'd3, 1'b1);
        tick();
        chk("lui wdata", bus.out_wdata, 32'h1234_5000);
        send(32'h304, 32'h3, 32'h5, 32'h77, 5'd0, 2'd1, 1'b1);
        tick();
        chk("rd0 valid", 32'(bus.out_valid), 32'd1);
        chk("rd0 we", 32'(bus.out_we), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        chk("retire before flush", retire_cnt, 32'd10);

        bus.out_ready = 1'b0;
        send(32'h400, 32'h33, 32'h40, 0, 5'd5, 2'd0, 1'b1);
        tick();
        send(32'h404, 32'h33, 32'h41, 0, 5'd6, 2'd0, 1'b1);
        tick();
        send(32'h408, 32'h33, 32'h42, 0, 5'd9, 2'd0, 1'b1);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush retire", retire_cnt, 32'd10);
        chk("flush we", 32'(bus.out_we), 32'd0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("flush dropped", 32'(bus.out_valid), 32'd0);

        pat_v = 16'b1011_1110_0111_1101;
        pat_r = 16'b0110_1101_1011_0011;
        for (int i = 0; i < 16; i++) begin
            send(32'h2000 + 32'(4 * i), 32'h0010_0037 * 32'(i + 1), 32'hA000 + 32'(i),
                 32'hB000 + 32'(i), 5'(i), 2'(i), 1'(i));
            bus.in_valid  = pat_v[i];
            bus.out_ready = pat_r[i];
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drain empty", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
